// File: rtl/mips_wb_regfile.sv
// ---------------------------------------------------------------------------
// mips_wb_regfile
//
// Write-back stage and architectural register file of the five-stage MIPS
// pipeline. The block selects the write-back value (ALU result or load data)
// and commits it to one of 2**ADDR_W general-purpose registers. It serves two
// combinational decode-stage read ports, and both ports see the current
// cycle's write through a bypass. It also counts retired (non-bubble)
// instructions and provides a debug read port that shows committed state only.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high; clears registers and counter
//   iRegWrite  in   MEM/WB write enable
//   iMemToReg  in   1: write back iMemData, 0: write back iResult
//   iResult    in   ALU result
//   iMemData   in   load data
//   iRegDest   in   destination register index
//   iIR        in   instruction word in write-back (0 = bubble)
//   iRsAddr    in   read port A index
//   iRtAddr    in   read port B index
//   oRsData    out  read port A data (bypassed)
//   oRtData    out  read port B data (bypassed)
//   oWbData    out  selected write-back value, for EX forwarding
//   oWbValid   out  a real register write is happening this cycle
//   iDbgAddr   in   debug read index
//   oDbgData   out  debug read data, storage only
//   oRetired   out  retired-instruction count, wraps modulo 2**32
// ---------------------------------------------------------------------------
module mips_wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iRegWrite,
    input  logic              iMemToReg,
    input  logic [DATA_W-1:0] iResult,
    input  logic [DATA_W-1:0] iMemData,
    input  logic [ADDR_W-1:0] iRegDest,
    input  logic [31:0]       iIR,
    input  logic [ADDR_W-1:0] iRsAddr,
    input  logic [ADDR_W-1:0] iRtAddr,
    output logic [DATA_W-1:0] oRsData,
    output logic [DATA_W-1:0] oRtData,
    output logic [DATA_W-1:0] oWbData,
    output logic              oWbValid,
    input  logic [ADDR_W-1:0] iDbgAddr,
    output logic [DATA_W-1:0] oDbgData,
    output logic [31:0]       oRetired
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [31:0]       retired_q;
    logic [31:0]       retired_d;
    logic [DATA_W-1:0] wdata;
    logic              wb_valid;

    assign wdata    = iMemToReg ? iMemData : iResult;
    // Index 0 is $zero, so a write aimed at it is not a real write.
    assign wb_valid = iRegWrite && (iRegDest != '0);

    // Read with write-through bypass. Index 0 returns 0 even if something
    // upstream tries to write it.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              byp_en,
        input logic [ADDR_W-1:0] byp_addr,
        input logic [DATA_W-1:0] byp_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] r;
        if (addr == '0) begin
            r = '0;
        end else if (byp_en && (addr == byp_addr)) begin
            r = byp_data;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    always_comb begin
        retired_d = retired_q;
        if (iIR != 32'b0) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            retired_q <= '0;
        end else begin
            // regs_q[0] is never written, so it stays at its reset value of 0.
            if (wb_valid) begin
                regs_q[iRegDest] <= wdata;
            end
            retired_q <= retired_d;
        end
    end

    assign oRsData  = read_port(iRsAddr, wb_valid, iRegDest, wdata, regs_q[iRsAddr]);
    assign oRtData  = read_port(iRtAddr, wb_valid, iRegDest, wdata, regs_q[iRtAddr]);
    assign oWbData  = wdata;
    assign oWbValid = wb_valid;
    assign oDbgData = regs_q[iDbgAddr];
    assign oRetired = retired_q;

endmodule

// File: tb/tb_mips_wb_regfile.sv
module tb_mips_wb_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic        iRegWrite;
    logic        iMemToReg;
    logic [31:0] iResult;
    logic [31:0] iMemData;
    logic [4:0]  iRegDest;
    logic [31:0] iIR;
    logic [4:0]  iRsAddr;
    logic [4:0]  iRtAddr;
    logic [31:0] oRsData;
    logic [31:0] oRtData;
    logic [31:0] oWbData;
    logic        oWbValid;
    logic [4:0]  iDbgAddr;
    logic [31:0] oDbgData;
    logic [31:0] oRetired;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state as plain arrays
    logic [31:0] ref_regs [32];
    logic [31:0] ref_retired;

    mips_wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .iRegWrite(iRegWrite),
        .iMemToReg(iMemToReg),
        .iResult  (iResult),
        .iMemData (iMemData),
        .iRegDest (iRegDest),
        .iIR      (iIR),
        .iRsAddr  (iRsAddr),
        .iRtAddr  (iRtAddr),
        .oRsData  (oRsData),
        .oRtData  (oRtData),
        .oWbData  (oWbData),
        .oWbValid (oWbValid),
        .iDbgAddr (iDbgAddr),
        .oDbgData (oDbgData),
        .oRetired (oRetired)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] m_wdata();
        return iMemToReg ? iMemData : iResult;
    endfunction

    function automatic logic m_valid();
        return iRegWrite && (iRegDest != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_valid() && a == iRegDest) return m_wdata();
        return ref_regs[a];
    endfunction

    // Advance one clock: apply the architectural effect of the current
    // inputs to the model at the edge, then return at the falling edge.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
            ref_retired = 32'd0;
        end else begin
            if (m_valid()) ref_regs[iRegDest] = m_wdata();
            if (iIR != 32'd0) ref_retired = ref_retired + 32'd1;
        end
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        iRegWrite = 1'b0; iMemToReg = 1'b0; iResult = 32'd0; iMemData = 32'd0;
        iRegDest = 5'd0; iIR = 32'd0; iRsAddr = 5'd0; iRtAddr = 5'd0; iDbgAddr = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            iDbgAddr = 5'(i);
            #1;
            checks++;
            if (oDbgData !== 32'd0) begin
                errors++;
                $display("FAIL reset_dbg[%0d] got=%h exp=%h", i, oDbgData, 32'd0);
            end
        end
        checks++;
        if (oRetired !== 32'd0) begin
            errors++; $display("FAIL reset_retired got=%h exp=0", oRetired);
        end
        iRsAddr = 5'd9; iRtAddr = 5'd17; #1;
        checks++;
        if (oRsData !== 32'd0 || oRtData !== 32'd0) begin
            errors++; $display("FAIL reset_ports got=%h/%h exp=0/0", oRsData, oRtData);
        end
        @(negedge clock);
    endtask

    task automatic test_write_read();
        iRegWrite = 1'b1; iMemToReg = 1'b0; iResult = 32'hDEADBEEF; iMemData = 32'h0;
        iRegDest = 5'd7; iIR = 32'h01234567; iRsAddr = 5'd7; iRtAddr = 5'd3; iDbgAddr = 5'd7;
        #1;
        checks++;
        if (oRsData !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_bypass got=%h exp=%h", oRsData, 32'hDEADBEEF);
        end
        checks++;
        if (oWbValid !== 1'b1) begin
            errors++; $display("FAIL wr_valid got=%b exp=1", oWbValid);
        end
        checks++;
        if (oDbgData !== 32'd0) begin
            errors++; $display("FAIL wr_dbg_before got=%h exp=0", oDbgData);
        end
        tick();
        iRegWrite = 1'b0; iIR = 32'd0;
        #1;
        checks++;
        if (oRsData !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_stored got=%h exp=%h", oRsData, 32'hDEADBEEF);
        end
        checks++;
        if (oDbgData !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_dbg got=%h exp=%h", oDbgData, 32'hDEADBEEF);
        end
        checks++;
        if (oRetired !== 32'd1) begin
            errors++; $display("FAIL wr_retired got=%h exp=1", oRetired);
        end
        @(negedge clock);
    endtask

    task automatic test_load_select();
        iRegWrite = 1'b1; iMemToReg = 1'b1; iMemData = 32'h0000CAFE; iResult = 32'h11111111;
        iRegDest = 5'd31; iIR = 32'h8C000000; iRtAddr = 5'd31; iDbgAddr = 5'd31;
        #1;
        checks++;
        if (oWbData !== 32'h0000CAFE) begin
            errors++; $display("FAIL load_wbdata got=%h exp=%h", oWbData, 32'h0000CAFE);
        end
        checks++;
        if (oRtData !== 32'h0000CAFE) begin
            errors++; $display("FAIL load_bypass got=%h exp=%h", oRtData, 32'h0000CAFE);
        end
        tick();
        iRegWrite = 1'b0; iIR = 32'd0;
        #1;
        checks++;
        if (oDbgData !== 32'h0000CAFE) begin
            errors++; $display("FAIL load_dbg got=%h exp=%h", oDbgData, 32'h0000CAFE);
        end
        @(negedge clock);
    endtask

    task automatic test_zero();
        iRegWrite = 1'b1; iMemToReg = 1'b0; iResult = 32'hFFFFFFFF; iRegDest = 5'd0;
        iIR = 32'h00000020; iRsAddr = 5'd0; iRtAddr = 5'd0; iDbgAddr = 5'd0;
        #1;
        checks++;
        if (oRsData !== 32'd0 || oRtData !== 32'd0) begin
            errors++; $display("FAIL zero_bypass got=%h/%h exp=0/0", oRsData, oRtData);
        end
        checks++;
        if (oWbValid !== 1'b0) begin
            errors++; $display("FAIL zero_valid got=%b exp=0", oWbValid);
        end
        checks++;
        if (oWbData !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL zero_wbdata got=%h exp=%h", oWbData, 32'hFFFFFFFF);
        end
        tick();
        iRegWrite = 1'b0; iIR = 32'd0;
        #1;
        checks++;
        if (oRsData !== 32'd0 || oRtData !== 32'd0 || oDbgData !== 32'd0) begin
            errors++;
            $display("FAIL zero_after got=%h/%h/%h exp=0/0/0", oRsData, oRtData, oDbgData);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        iRegWrite = 1'b1; iMemToReg = 1'b0; iRegDest = 5'd12; iRsAddr = 5'd12;
        iRtAddr = 5'd12; iDbgAddr = 5'd12; iIR = 32'h1;
        for (int k = 0; k < 3; k++) begin
            iResult = 32'hA0A00000 + 32'(k);
            #1;
            checks++;
            if (oRsData !== iResult || oRtData !== iResult) begin
                errors++;
                $display("FAIL b2b_bypass[%0d] got=%h/%h exp=%h", k, oRsData, oRtData, iResult);
            end
            checks++;
            if (oDbgData !== ref_regs[12]) begin
                errors++; $display("FAIL b2b_dbg[%0d] got=%h exp=%h", k, oDbgData, ref_regs[12]);
            end
            tick();
        end
        iRegWrite = 1'b0; iIR = 32'd0;
        #1;
        checks++;
        if (oDbgData !== 32'hA0A00002) begin
            errors++; $display("FAIL b2b_last got=%h exp=%h", oDbgData, 32'hA0A00002);
        end
        @(negedge clock);
    endtask

    task automatic test_wrap();
        idle_inputs();
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        ref_retired = 32'hFFFFFFFF;
        #1;
        checks++;
        if (oRetired !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL wrap_preload got=%h exp=%h", oRetired, 32'hFFFFFFFF);
        end
        iIR = 32'hAC000000;   // store: counted even without a register write
        tick();
        iIR = 32'd0;
        #1;
        checks++;
        if (oRetired !== 32'd0) begin
            errors++; $display("FAIL wrap_zero got=%h exp=0", oRetired);
        end
        repeat (5) tick();
        #1;
        checks++;
        if (oRetired !== 32'd0) begin
            errors++; $display("FAIL bubble_hold got=%h exp=0", oRetired);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_vs_write();
        iRegWrite = 1'b1; iMemToReg = 1'b0; iResult = 32'h00001234; iRegDest = 5'd5; iIR = 32'h5;
        tick();
        reset = 1'b1; iResult = 32'h00000055; iIR = 32'h6;
        tick();
        reset = 1'b0; iRegWrite = 1'b0; iIR = 32'd0; iDbgAddr = 5'd5;
        #1;
        checks++;
        if (oDbgData !== 32'd0) begin
            errors++; $display("FAIL rst_vs_wr_reg got=%h exp=0", oDbgData);
        end
        checks++;
        if (oRetired !== 32'd0) begin
            errors++; $display("FAIL rst_vs_wr_retired got=%h exp=0", oRetired);
        end
        @(negedge clock);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 59) == 0);
            iRegWrite = $urandom_range(0, 3) != 0;
            iMemToReg = $urandom_range(0, 1) == 1;
            iResult   = $urandom;
            iMemData  = $urandom;
            iRegDest  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            iIR       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom | 32'd1;
            iRsAddr   = ($urandom_range(0, 1) == 0) ? iRegDest : 5'($urandom_range(0, 31));
            iRtAddr   = 5'($urandom_range(0, 7));
            iDbgAddr  = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (oRsData !== m_read(iRsAddr)) begin
                errors++; $display("FAIL rnd_rs[%0d] got=%h exp=%h", n, oRsData, m_read(iRsAddr));
            end
            checks++;
            if (oRtData !== m_read(iRtAddr)) begin
                errors++; $display("FAIL rnd_rt[%0d] got=%h exp=%h", n, oRtData, m_read(iRtAddr));
            end
            checks++;
            if (oWbData !== m_wdata() || oWbValid !== m_valid()) begin
                errors++;
                $display("FAIL rnd_wb[%0d] got=%h/%b exp=%h/%b", n, oWbData, oWbValid, m_wdata(), m_valid());
            end
            checks++;
            if (oDbgData !== ref_regs[iDbgAddr]) begin
                errors++; $display("FAIL rnd_dbg[%0d] got=%h exp=%h", n, oDbgData, ref_regs[iDbgAddr]);
            end
            checks++;
            if (oRetired !== ref_retired) begin
                errors++; $display("FAIL rnd_retired[%0d] got=%h exp=%h", n, oRetired, ref_retired);
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            iDbgAddr = 5'(i);
            #1;
            checks++;
            if (oDbgData !== ref_regs[i]) begin
                errors++; $display("FAIL rnd_final[%0d] got=%h exp=%h", i, oDbgData, ref_regs[i]);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        ref_retired = 32'd0;
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        test_reset();
        test_write_read();
        test_load_select();
        test_zero();
        test_back_to_back();
        test_wrap();
        test_reset_vs_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
